// File: rtl/aoi_arb_pkg.sv
// aoi_arb_pkg: shared types and constants for the two-requester hold-limited arbiter.
//   state_e    : arbiter FSM state (IDLE, GNT_A, GNT_B)
//   req_id_e   : requester identity, used for the last_served record
//   MAX_HOLD_DEF / HOLD_W : default hold limit and hold counter width
package aoi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int unsigned MAX_HOLD_DEF = 8;
  localparam int unsigned HOLD_W       = 4;

endpackage

// File: rtl/aoi_arb_if.sv
// aoi_arb_if: request/grant bundle between requesters and the arbiter.
//   en, req_a, req_b, rel_a, rel_b : driven by the requester side (master)
//   gnt_a, gnt_b, busy, err        : driven by the arbiter (slave)
interface aoi_arb_if;

  logic en;
  logic req_a;
  logic req_b;
  logic rel_a;
  logic rel_b;
  logic gnt_a;
  logic gnt_b;
  logic busy;
  logic err;

  modport master (
    output en, req_a, req_b, rel_a, rel_b,
    input  gnt_a, gnt_b, busy, err
  );

  modport slave (
    input  en, req_a, req_b, rel_a, rel_b,
    output gnt_a, gnt_b, busy, err
  );

endinterface

// File: rtl/aoi_hold_cnt.sv
// aoi_hold_cnt: counts consecutive grant cycles of the current owner.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : force count to 0 (highest priority)
//   i_load     : load 1 (first grant cycle)
//   i_inc      : add 1, saturating at the counter maximum
//   o_cnt      : current count
//   o_at_max   : count equals MAX_HOLD
module aoi_hold_cnt
  import aoi_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_inc,
  output logic [HOLD_W-1:0] o_cnt,
  output logic              o_at_max
);

  logic [HOLD_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= HOLD_W'(1);
    end else if (i_inc && (r_cnt != '1)) begin
      // Saturation is a backstop; the FSM revokes at MAX_HOLD long before.
      r_cnt <= r_cnt + HOLD_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == HOLD_W'(MAX_HOLD));

endmodule

// File: rtl/aoi_arb.sv
// aoi_arb: two-requester arbiter for a shared AND-OR resource.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : aoi_arb_if slave side (en/req/rel in, gnt/busy/err out)
// A tie in IDLE goes to the requester not served last. A grant ends on
// release, dropped request, disable, or after MAX_HOLD cycles (err pulse).
// Every grant is followed by at least one IDLE cycle.
module aoi_arb
  import aoi_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  aoi_arb_if.slave     bus
);

  state_e            r_state;
  state_e            w_state_d;
  req_id_e           r_last;
  req_id_e           w_last_d;
  req_id_e           w_pick;
  logic              r_gnt_a;
  logic              r_gnt_b;
  logic              r_busy;
  logic              r_err;
  logic              w_timeout;
  logic              w_clr;
  logic              w_load;
  logic              w_inc;
  logic              w_own_req;
  logic              w_own_rel;
  logic              w_at_max;
  logic [HOLD_W-1:0] w_hold_cnt;

  aoi_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_load   (w_load),
    .i_inc    (w_inc),
    .o_cnt    (w_hold_cnt),
    .o_at_max (w_at_max)
  );

  // Request/release of whoever currently owns the grant; the other
  // requester's release is ignored.
  always_comb begin
    w_own_req = 1'b0;
    w_own_rel = 1'b0;
    if (r_state == GNT_A) begin
      w_own_req = bus.req_a;
      w_own_rel = bus.rel_a;
    end else if (r_state == GNT_B) begin
      w_own_req = bus.req_b;
      w_own_rel = bus.rel_b;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    w_timeout = 1'b0;
    w_clr     = 1'b0;
    w_load    = 1'b0;
    w_inc     = 1'b0;
    w_pick    = REQ_A;
    if (bus.req_a && bus.req_b) begin
      w_pick = (r_last == REQ_B) ? REQ_A : REQ_B;
    end else if (!bus.req_a) begin
      w_pick = REQ_B;
    end
    unique case (r_state)
      IDLE: begin
        if (bus.en && (bus.req_a || bus.req_b)) begin
          w_state_d = (w_pick == REQ_A) ? GNT_A : GNT_B;
          w_last_d  = w_pick;
          w_load    = 1'b1;
        end else begin
          w_clr = 1'b1;
        end
      end
      GNT_A, GNT_B: begin
        // Disable and release win over the timeout, so no err in those cases.
        if (!bus.en || w_own_rel || !w_own_req) begin
          w_state_d = IDLE;
          w_clr     = 1'b1;
        end else if (w_at_max) begin
          w_state_d = IDLE;
          w_clr     = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= REQ_B;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
      r_gnt_a <= (w_state_d == GNT_A);
      r_gnt_b <= (w_state_d == GNT_B);
      r_busy  <= (w_state_d != IDLE);
      r_err   <= w_timeout;
    end
  end

  assign bus.gnt_a = r_gnt_a;
  assign bus.gnt_b = r_gnt_b;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;

  logic unused_hold_cnt;
  assign unused_hold_cnt = ^w_hold_cnt;

endmodule

// File: tb/tb_aoi_arb.sv
// tb_aoi_arb: directed scenarios plus randomized traffic, every cycle checked
// against a cycle-level reference model of the arbitration rules.
module tb_aoi_arb;

  localparam int unsigned MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_check = 0;
  int   n_fail  = 0;

  // Reference model: owner 0 = none, 1 = A, 2 = B.
  int   m_owner = 0;
  int   m_hold  = 0;
  int   m_last  = 2;
  bit   m_err   = 1'b0;

  aoi_arb_if bus ();

  aoi_arb #(
    .MAX_HOLD (MAX_HOLD)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_check++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit en, input bit ra, input bit rb, input bit la, input bit lb);
    bus.en    = en;
    bus.req_a = ra;
    bus.req_b = rb;
    bus.rel_a = la;
    bus.rel_b = lb;
  endtask

  // One rising edge of the arbitration rules, applied to the sampled inputs.
  function automatic void model_edge();
    int my_req;
    int my_rel;
    if (!rst_n) begin
      m_owner = 0;
      m_hold  = 0;
      m_last  = 2;
      m_err   = 1'b0;
    end else if (m_owner == 0) begin
      m_err = 1'b0;
      if (bus.en && (bus.req_a || bus.req_b)) begin
        if (bus.req_a && bus.req_b) m_owner = (m_last == 1) ? 2 : 1;
        else                        m_owner = bus.req_a ? 1 : 2;
        m_last = m_owner;
        m_hold = 1;
      end
    end else begin
      my_req = (m_owner == 1) ? int'(bus.req_a) : int'(bus.req_b);
      my_rel = (m_owner == 1) ? int'(bus.rel_a) : int'(bus.rel_b);
      if (!bus.en || my_rel != 0 || my_req == 0) begin
        m_owner = 0;
        m_hold  = 0;
        m_err   = 1'b0;
      end else if (m_hold == int'(MAX_HOLD)) begin
        m_owner = 0;
        m_hold  = 0;
        m_err   = 1'b1;
      end else begin
        m_hold++;
        m_err = 1'b0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt_a", int'(bus.gnt_a), int'(m_owner == 1));
    check("gnt_b", int'(bus.gnt_b), int'(m_owner == 2));
    check("busy",  int'(bus.busy),  int'(m_owner != 0));
    check("err",   int'(bus.err),   int'(m_err));
    check("excl",  int'(bus.gnt_a && bus.gnt_b), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int wins[$];
    int exp_seq[4];
    int run;
    int run_len;
    int err_at_fall;
    int grants;
    bit prev_a;
    bit prev_b;
    bit fell;

    exp_seq = '{1, 2, 1, 2};
    rst_n   = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state and single-requester grant/release.
    do_reset();
    check("rst_busy", int'(bus.busy), 0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("a_grant", int'(bus.gnt_a), 1);
    step();
    bus.rel_a = 1'b1;
    step();
    check("a_rel_drop", int'(bus.gnt_a), 0);
    check("a_rel_err", int'(bus.err), 0);
    bus.rel_a = 1'b0;
    step();

    // Both requesting, each releasing after two grant cycles: strict alternation.
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run    = 0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.gnt_a && !prev_a) wins.push_back(1);
      if (bus.gnt_b && !prev_b) wins.push_back(2);
      run       = (bus.gnt_a || bus.gnt_b) ? run + 1 : 0;
      bus.rel_a = bus.gnt_a && (run == 2);
      bus.rel_b = bus.gnt_b && (run == 2);
      prev_a    = bus.gnt_a;
      prev_b    = bus.gnt_b;
    end
    check("alt_cnt", int'(wins.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      check("alt_seq", (i < wins.size()) ? wins[i] : 0, exp_seq[i]);
    end

    // Hold timeout on B: MAX_HOLD grant cycles, err at the fall, regrant after idle.
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run         = 0;
    run_len     = 0;
    err_at_fall = 0;
    fell        = 1'b0;
    prev_b      = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.gnt_b) run++;
      if (prev_b && !bus.gnt_b && !fell) begin
        fell        = 1'b1;
        run_len     = run;
        err_at_fall = int'(bus.err);
      end
      prev_b = bus.gnt_b;
    end
    check("hold_len", run_len, int'(MAX_HOLD));
    check("hold_err", err_at_fall, 1);

    // Disable revokes without err; no grants while disabled.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    bus.en    = 1'b0;
    bus.rel_a = 1'b1;
    step();
    check("dis_drop", int'(bus.gnt_a), 0);
    check("dis_err", int'(bus.err), 0);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      grants += int'(bus.busy);
    end
    check("dis_nogrant", grants, 0);

    // Reset mid-grant, then A wins the first tie.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mid_rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("tie_after_rst", int'(bus.gnt_a), 1);

    // Foreign release ignored; release at the hold limit is a normal release.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < int'(MAX_HOLD); i++) step();
    check("rel_b_ignored", int'(bus.gnt_a), 1);
    bus.rel_a = 1'b1;
    step();
    check("rel_max_drop", int'(bus.gnt_a), 0);
    check("rel_max_err", int'(bus.err), 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      bus.en    = ($urandom_range(0, 19) != 0);
      bus.req_a = ($urandom_range(0, 9) != 0);
      bus.req_b = ($urandom_range(0, 5) != 0);
      bus.rel_a = ($urandom_range(0, 15) == 0);
      bus.rel_b = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
